// File: rtl/axi_sw_master.sv
// Pushbutton-driven AXI-lite-style master: debounced rd/wr presses launch one
// handshake transaction each, with a per-transaction timeout and status outputs.

module axi_sw_master_deb #(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q, prev_q;
    logic          lvl_q, lvl_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Counter only advances while the synced level disagrees with the accepted one.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == DW'(DEB_CYCLES - 1)) lvl_d = sync2_q;
            else                              cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
        end
    end

    assign press = lvl_q & ~prev_q;
endmodule

module axi_sw_master #(
    parameter int DEB_CYCLES     = 20000,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_rd,
    input  logic             btn_wr,
    input  logic [3:0]       sw_addr,
    input  logic [3:0]       sw_data,
    input  logic             sm_arready,
    input  logic             sm_rvalid,
    input  logic             sm_awready,
    input  logic             sm_wready,
    output logic             ms_arvalid,
    output logic             ms_rready,
    output logic             ms_awvalid,
    output logic             ms_wvalid,
    output logic [3:0]       SWM_arADDR,
    output logic [3:0]       SWM_wdata,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] txn_count
);
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, DONE} state_t;

    logic [1:0] btn_raw, btn_evt;
    logic       rd_evt, wr_evt;

    assign btn_raw = {btn_wr, btn_rd};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        axi_sw_master_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw[g]),
            .press (btn_evt[g])
        );
    end

    assign rd_evt = btn_evt[0];
    assign wr_evt = btn_evt[1];

    state_t           state_q, state_d;
    logic             arvalid_q, arvalid_d, rready_q, rready_d;
    logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [3:0]       addr_q, addr_d, data_q, data_d;
    logic             busy_q, busy_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             waiting, progress, aw_hs, w_hs;

    assign aw_hs = awvalid_q & sm_awready;
    assign w_hs  = wvalid_q & sm_wready;

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        waiting   = 1'b0;
        progress  = 1'b0;

        case (state_q)
            IDLE: begin
                // Read wins a same-cycle tie; the write event is simply lost.
                if (rd_evt || wr_evt) begin
                    addr_d = sw_addr;
                    data_d = sw_data;
                    err_d  = 1'b0;
                    to_d   = '0;
                    if (rd_evt) begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            RD_ADDR: begin
                waiting = 1'b1;
                if (arvalid_q && sm_arready) begin
                    progress  = 1'b1;
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                waiting = 1'b1;
                if (rready_q && sm_rvalid) begin
                    progress = 1'b1;
                    state_d  = DONE;
                    rready_d = 1'b0;
                end
            end
            WR: begin
                waiting = 1'b1;
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                progress = aw_hs | w_hs;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = DONE;
            end
            DONE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A completed handshake buys a fresh timeout window; silence runs it down.
        if (waiting) begin
            if (progress) begin
                to_d = '0;
            end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                err_d     = 1'b1;
                to_d      = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
        end
    end

    assign ms_arvalid = arvalid_q;
    assign ms_rready  = rready_q;
    assign ms_awvalid = awvalid_q;
    assign ms_wvalid  = wvalid_q;
    assign SWM_arADDR = addr_q;
    assign SWM_wdata  = data_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign txn_count  = cnt_q;
endmodule

// File: tb/tb_axi_sw_master.sv
// Directed bench for axi_sw_master: a cycle table for the skewed-ready write
// plus hand sequences for bounce, arbitration, busy drop, timeout and reset.

module tb_axi_sw_master;
    localparam int DEB = 4;
    localparam int TO  = 8;

    logic       clk = 1'b0, reset = 1'b1, btn_rd = 1'b0, btn_wr = 1'b0;
    logic [3:0] sw_addr = '0, sw_data = '0;
    logic       sm_arready = 1'b0, sm_rvalid = 1'b0, sm_awready = 1'b0, sm_wready = 1'b0;
    logic       ms_arvalid, ms_rready, ms_awvalid, ms_wvalid, busy, err;
    logic [3:0] SWM_arADDR, SWM_wdata;
    logic [7:0] txn_count;

    int checks = 0;
    int errors = 0;

    axi_sw_master #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .btn_rd(btn_rd), .btn_wr(btn_wr),
        .sw_addr(sw_addr), .sw_data(sw_data),
        .sm_arready(sm_arready), .sm_rvalid(sm_rvalid),
        .sm_awready(sm_awready), .sm_wready(sm_wready),
        .ms_arvalid(ms_arvalid), .ms_rready(ms_rready),
        .ms_awvalid(ms_awvalid), .ms_wvalid(ms_wvalid),
        .SWM_arADDR(SWM_arADDR), .SWM_wdata(SWM_wdata),
        .busy(busy), .err(err), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // Expected-output layout: {arv, rr, awv, wv, addr, data, busy, err, cnt}
    typedef struct packed {
        logic        rd, wr;
        logic [3:0]  a, d;
        logic        arr, rv, awr, wrr;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [21:0] ex(logic arv, logic rr, logic awv, logic wv,
                                       logic [3:0] ad, logic [3:0] da,
                                       logic b, logic er, logic [7:0] c);
        return {arv, rr, awv, wv, ad, da, b, er, c};
    endfunction

    function automatic vec_t mk(logic rd, logic wr, logic [3:0] a, logic [3:0] d,
                                logic arr, logic rv, logic awr, logic wrr, logic [21:0] e);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.d = d;
        v.arr = arr; v.rv = rv; v.awr = awr; v.wrr = wrr; v.exp = e;
        return v;
    endfunction

    function automatic logic [21:0] obs();
        return {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid, SWM_arADDR, SWM_wdata,
                busy, err, txn_count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Returns the number of cycles until the chosen valid rises, 0 if it never does.
    task automatic wait_valid(input bit aw, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (aw ? ms_awvalid : ms_arvalid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  bad;

        // reset with read button held
        btn_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset_outs%0d", i), obs(), 0);
        end
        reset  = 1'b0;
        btn_rd = 1'b0;
        for (int i = 0; i < DEB + 2; i++) begin
            step();
            chk($sformatf("post_reset%0d", i), obs(), 0);
        end

        // write with wready on cycle 1, awready on cycle 4; switches move mid-flight
        for (int i = 0; i < 6; i++)
            tbl[i] = mk(0, 1, 4'h3, 4'hC, 0, 0, 0, 0, ex(0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 8'd0));
        tbl[6]  = mk(0, 1, 4'h3, 4'hC, 0, 0, 0, 0, ex(0, 0, 1, 1, 4'h3, 4'hC, 1, 0, 8'd0));
        tbl[7]  = mk(0, 1, 4'h5, 4'h6, 0, 0, 0, 0, ex(0, 0, 1, 1, 4'h3, 4'hC, 1, 0, 8'd0));
        tbl[8]  = mk(0, 1, 4'h5, 4'h6, 0, 0, 0, 1, ex(0, 0, 1, 0, 4'h3, 4'hC, 1, 0, 8'd0));
        tbl[9]  = mk(0, 0, 4'h5, 4'h6, 0, 0, 0, 0, ex(0, 0, 1, 0, 4'h3, 4'hC, 1, 0, 8'd0));
        tbl[10] = mk(0, 0, 4'h5, 4'h6, 0, 0, 0, 0, ex(0, 0, 1, 0, 4'h3, 4'hC, 1, 0, 8'd0));
        tbl[11] = mk(0, 0, 4'h5, 4'h6, 0, 0, 1, 0, ex(0, 0, 0, 0, 4'h3, 4'hC, 1, 0, 8'd0));
        tbl[12] = mk(0, 0, 4'h5, 4'h6, 0, 0, 0, 0, ex(0, 0, 0, 0, 4'h3, 4'hC, 0, 0, 8'd1));
        for (int i = 0; i < 13; i++) begin
            btn_rd = tbl[i].rd;  btn_wr = tbl[i].wr;
            sw_addr = tbl[i].a;  sw_data = tbl[i].d;
            sm_arready = tbl[i].arr; sm_rvalid = tbl[i].rv;
            sm_awready = tbl[i].awr; sm_wready = tbl[i].wrr;
            step();
            chk($sformatf("wr_vec%0d", i), obs(), tbl[i].exp);
        end
        sm_awready = 1'b0; sm_wready = 1'b0;
        idle(12);

        // bouncy read
        sw_addr = 4'hA; sw_data = 4'h1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_rd = ((i % 4) < 2);
            step();
            if (ms_arvalid || busy) bad = 1'b1;
        end
        chk("bounce_no_event", bad, 0);
        btn_rd = 1'b1;
        wait_valid(1'b0, n);
        chk("rd_deb_latency", n, DEB + 3);
        chk("rd_addr", SWM_arADDR, 4'hA);
        sw_addr = 4'hF;
        step();
        chk("rd_arvalid_hold", {ms_arvalid, ms_rready}, 2'b10);
        sm_arready = 1'b1;
        step();
        chk("rd_ar_hs", {ms_arvalid, ms_rready}, 2'b01);
        sm_arready = 1'b0;
        step();
        chk("rd_rready_hold1", {ms_arvalid, ms_rready}, 2'b01);
        step();
        chk("rd_rready_hold2", {ms_arvalid, ms_rready, SWM_arADDR}, {2'b01, 4'hA});
        sm_rvalid = 1'b1;
        step();
        chk("rd_done_state", {ms_arvalid, ms_rready, busy, txn_count}, {3'b001, 8'd1});
        sm_rvalid = 1'b0;
        step();
        chk("rd_complete", {busy, txn_count, SWM_arADDR}, {1'b0, 8'd2, 4'hA});
        btn_rd = 1'b0;
        idle(12);

        // simultaneous rd+wr press: read wins
        sw_addr = 4'h5;
        btn_rd = 1'b1; btn_wr = 1'b1;
        wait_valid(1'b0, n);
        chk("simul_rd_launch", n, DEB + 3);
        chk("simul_no_wr", {ms_awvalid, ms_wvalid}, 2'b00);
        sm_arready = 1'b1; sm_rvalid = 1'b1;
        step();
        chk("simul_rd_data", {ms_arvalid, ms_rready}, 2'b01);
        step();
        chk("simul_done", {ms_rready, busy}, 2'b01);
        sm_arready = 1'b0; sm_rvalid = 1'b0;
        step();
        chk("simul_count", {busy, txn_count}, {1'b0, 8'd3});
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ms_awvalid || ms_wvalid || busy) bad = 1'b1;
        end
        chk("simul_wr_dropped", bad, 0);
        btn_rd = 1'b0; btn_wr = 1'b0;
        idle(12);

        // write press landing during RD_DATA; early arready must wait for arvalid
        sw_addr = 4'h9;
        btn_rd = 1'b1;
        idle(3);
        btn_wr = 1'b1;
        idle(3);
        chk("busy_pre_launch", busy, 0);
        sm_arready = 1'b1;
        step();
        chk("early_ready_ignored", {ms_arvalid, ms_rready, busy}, 3'b101);
        step();
        chk("early_ready_hs", {ms_arvalid, ms_rready}, 2'b01);
        sm_arready = 1'b0;
        step();
        step();
        chk("wr_evt_in_rd_data", {ms_rready, ms_awvalid, ms_wvalid, busy}, 4'b1001);
        sm_rvalid = 1'b1;
        step();
        sm_rvalid = 1'b0;
        step();
        chk("busy_rd_complete", {busy, txn_count, SWM_arADDR}, {1'b0, 8'd4, 4'h9});
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ms_awvalid || ms_wvalid || busy) bad = 1'b1;
        end
        chk("no_queued_write", bad, 0);
        btn_rd = 1'b0; btn_wr = 1'b0;
        idle(12);

        // timeout on a write the slave never answers
        sw_addr = 4'h7; sw_data = 4'h1;
        btn_wr = 1'b1;
        wait_valid(1'b1, n);
        chk("to_launch", n, DEB + 3);
        btn_wr = 1'b0;
        bad = 1'b0;
        for (int k = 1; k < TO; k++) begin
            step();
            if (!(ms_awvalid && ms_wvalid && busy)) bad = 1'b1;
        end
        chk("to_valids_held", bad, 0);
        step();
        chk("to_abort", {ms_awvalid, ms_wvalid, busy, err, txn_count}, {4'b0001, 8'd4});
        idle(12);
        chk("to_err_sticky", {err, busy}, 2'b10);

        // next read clears err, then reset lands in RD_DATA
        sw_addr = 4'h2;
        btn_rd = 1'b1;
        wait_valid(1'b0, n);
        chk("err_clear_launch", {n[7:0], err, SWM_arADDR}, {8'(DEB + 3), 1'b0, 4'h2});
        sm_arready = 1'b1;
        step();
        chk("mid_rd_data", {ms_rready, busy}, 2'b11);
        sm_arready = 1'b0;
        reset = 1'b1;
        step();
        chk("mid_reset", obs(), 0);
        reset  = 1'b0;
        btn_rd = 1'b0;
        step();
        chk("post_mid_reset", obs(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
